// File: rtl/axis_agg_if.sv
// ============================================================================
// Module      : axis_agg_if
// Description : AXI-Stream handshake bundle used by axis_packet_aggregator.
//               tuser is present only when AGG_TUSER_SOF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_agg_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;
`ifdef AGG_TUSER_SOF_EN
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

`default_nettype wire

// File: rtl/axis_packet_aggregator.sv
// ============================================================================
// Module      : axis_packet_aggregator
// Description : Merges N input packets into one output frame by suppressing
//               tlast on all but the Nth packet; flush request, frame counter
//               and a two-entry skid output stage. Optional start-of-frame
//               tuser marker enabled by defining AGG_TUSER_SOF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_packet_aggregator #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic             aclk,
    input  wire logic             rst,
    input  wire logic [CNT_W-1:0] packets_per_frame,
    input  wire logic             flush,
    axis_agg_if.slave             s_axis,
    axis_agg_if.master            m_axis,
    output logic [31:0]           frame_count,
    output logic                  busy
);

`ifdef AGG_TUSER_SOF_EN
    localparam int c_USER_W = 1;
`else
    localparam int c_USER_W = 0;
`endif
    // Payload layout: {[tuser], tlast, tdata}
    localparam int               c_PAY_W = DATA_W + 1 + c_USER_W;
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    logic [CNT_W-1:0]   r_ppf;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic               r_flush_pending;
    logic               r_s_ready;
    logic               r_main_valid;
    logic [c_PAY_W-1:0] r_main_pay;
    logic               r_skid_valid;
    logic [c_PAY_W-1:0] r_skid_pay;
    logic [31:0]        r_frame_count;
`ifdef AGG_TUSER_SOF_EN
    logic               r_sof;
`endif

    logic [CNT_W-1:0]   w_ppf_in;
    logic               w_accept;
    logic               w_accept_last;
    logic               w_close;
    logic               w_m_hs;
    logic [c_PAY_W-1:0] w_in_pay;

    logic [CNT_W-1:0]   w_ppf_n;
    logic [CNT_W-1:0]   w_pkt_cnt_n;
    logic               w_flush_pending_n;
    logic               w_main_valid_n;
    logic [c_PAY_W-1:0] w_main_pay_n;
    logic               w_skid_valid_n;
    logic [c_PAY_W-1:0] w_skid_pay_n;
    logic [31:0]        w_frame_count_n;

    always_comb begin
        w_ppf_in      = (packets_per_frame == '0) ? c_ONE : packets_per_frame;
        w_accept      = s_axis.tvalid & r_s_ready;
        w_accept_last = w_accept & s_axis.tlast;
        w_close       = w_accept_last &
                        ((r_pkt_cnt == (r_ppf - c_ONE)) | r_flush_pending | flush);
        w_m_hs        = r_main_valid & m_axis.tready;
`ifdef AGG_TUSER_SOF_EN
        w_in_pay      = {r_sof, w_close, s_axis.tdata};
`else
        w_in_pay      = {w_close, s_axis.tdata};
`endif
    end

    // Packet/frame bookkeeping: only accepted tlast beats move the count
    always_comb begin
        w_ppf_n           = r_ppf;
        w_pkt_cnt_n       = r_pkt_cnt;
        w_flush_pending_n = r_flush_pending;
        w_frame_count_n   = r_frame_count;

        if (w_accept_last) begin
            if (w_close) begin
                w_pkt_cnt_n       = '0;
                w_flush_pending_n = 1'b0;
                w_ppf_n           = w_ppf_in;
            end else begin
                w_pkt_cnt_n       = r_pkt_cnt + c_ONE;
            end
        end else if (flush) begin
            w_flush_pending_n = 1'b1;
        end

        if (w_m_hs && r_main_pay[DATA_W]) begin
            w_frame_count_n = r_frame_count + 32'd1;
        end
    end

    // Output register slice; input is stalled only while skid holds a beat
    always_comb begin
        w_main_valid_n = r_main_valid;
        w_main_pay_n   = r_main_pay;
        w_skid_valid_n = r_skid_valid;
        w_skid_pay_n   = r_skid_pay;

        if (w_accept) begin
            if (!r_main_valid || w_m_hs) begin
                w_main_valid_n = 1'b1;
                w_main_pay_n   = w_in_pay;
            end else begin
                w_skid_valid_n = 1'b1;
                w_skid_pay_n   = w_in_pay;
            end
        end else if (w_m_hs) begin
            if (r_skid_valid) begin
                w_main_pay_n   = r_skid_pay;
                w_skid_valid_n = 1'b0;
            end else begin
                w_main_valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!rst) begin
            r_ppf           <= w_ppf_in;
            r_pkt_cnt       <= '0;
            r_flush_pending <= 1'b0;
            r_s_ready       <= 1'b0;
            r_main_valid    <= 1'b0;
            r_main_pay      <= '0;
            r_skid_valid    <= 1'b0;
            r_skid_pay      <= '0;
            r_frame_count   <= '0;
        end else begin
            r_ppf           <= w_ppf_n;
            r_pkt_cnt       <= w_pkt_cnt_n;
            r_flush_pending <= w_flush_pending_n;
            r_s_ready       <= !w_skid_valid_n;
            r_main_valid    <= w_main_valid_n;
            r_main_pay      <= w_main_pay_n;
            r_skid_valid    <= w_skid_valid_n;
            r_skid_pay      <= w_skid_pay_n;
            r_frame_count   <= w_frame_count_n;
        end
    end

`ifdef AGG_TUSER_SOF_EN
    // Set on reset and after every closing beat: the next beat opens a frame
    always_ff @(posedge aclk) begin
        if (!rst) begin
            r_sof <= 1'b1;
        end else if (w_accept) begin
            r_sof <= w_close;
        end
    end

    assign m_axis.tuser = r_main_pay[DATA_W+1];
`endif

    assign s_axis.tready = r_s_ready;
    assign m_axis.tvalid = r_main_valid;
    assign m_axis.tlast  = r_main_pay[DATA_W];
    assign m_axis.tdata  = r_main_pay[DATA_W-1:0];
    assign frame_count   = r_frame_count;
    assign busy          = (r_pkt_cnt != '0) | r_flush_pending | r_main_valid | r_skid_valid;

endmodule

`default_nettype wire
